// File: rtl/pulse_train_scheduler.sv
// Pulse-train sequencer for the DDS front end: turns a start request plus width/count/period
// settings into a cycle-accurate GATE with per-pulse strobes, using a 32-entry period table.
module pulse_train_scheduler #(
    parameter int unsigned CLK_PER_US     = 500,
    parameter int unsigned CNT_W          = 23,
    parameter int unsigned DEFAULT_PERIOD = 360
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SIGN_START_GEN,
    input  logic [9:0]  T_IMPULSE,
    input  logic [5:0]  NUM_OF_IMP,
    input  logic        VOBULATION,
    input  logic        PERIOD_WR_EN,
    input  logic [4:0]  PERIOD_WR_ADDR,
    input  logic [12:0] PERIOD_WR_DATA,
    output logic        GATE,
    output logic        IMP_START,
    output logic [5:0]  IMP_INDEX,
    output logic        BUSY,
    output logic        DONE,
    output logic        CFG_ERR
);

    localparam int unsigned TW    = 10;
    localparam int unsigned NW    = 6;
    localparam int unsigned PW    = 13;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     period_tbl [DEPTH];
    logic              start_q;
    logic              rise_c;
    logic [TW-1:0]     t_lat_q, t_lat_d;
    logic [NW-1:0]     num_lat_q, num_lat_d;
    logic              vob_lat_q, vob_lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  w_cyc_q, w_cyc_d;
    logic [CNT_W-1:0]  p_cyc_q, p_cyc_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic              cfg_err_q, cfg_err_d;
    logic              gate_q, gate_d;
    logic              imp_start_q, imp_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [TW-1:0]     sel_t_c;
    logic              sel_vob_c;
    logic [NW-1:0]     idx_inc_c;
    logic [NW-1:0]     sel_idx_c;
    logic [PW-1:0]     entry_c;
    logic [PW-1:0]     min_p_c;
    logic [PW-1:0]     eff_p_c;
    logic              clamp_c;
    logic              new_pulse_c;

    assign rise_c    = SIGN_START_GEN & ~start_q;
    assign GATE      = gate_q;
    assign IMP_START = imp_start_q;
    assign IMP_INDEX = idx_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CFG_ERR   = cfg_err_q;

    // Period table; writes are accepted in every state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                period_tbl[i] <= PW'(DEFAULT_PERIOD);
            end
        end else if (PERIOD_WR_EN) begin
            period_tbl[PERIOD_WR_ADDR] <= PERIOD_WR_DATA;
        end
    end

    // Period for the pulse about to start; first pulse of a train uses the live inputs
    always_comb begin
        idx_inc_c = idx_q + NW'(1);
        sel_t_c   = (state_q == S_IDLE) ? T_IMPULSE  : t_lat_q;
        sel_vob_c = (state_q == S_IDLE) ? VOBULATION : vob_lat_q;
        sel_idx_c = (state_q == S_IDLE) ? NW'(0)     : idx_inc_c;
        entry_c   = period_tbl[sel_vob_c ? sel_idx_c[AW-1:0] : AW'(0)];
        min_p_c   = PW'(sel_t_c) + PW'(1);
        clamp_c   = entry_c < min_p_c;
        eff_p_c   = clamp_c ? min_p_c : entry_c;
    end

    always_comb begin
        state_d     = state_q;
        t_lat_d     = t_lat_q;
        num_lat_d   = num_lat_q;
        vob_lat_d   = vob_lat_q;
        cnt_d       = cnt_q + CNT_W'(1);
        w_cyc_d     = w_cyc_q;
        p_cyc_d     = p_cyc_q;
        idx_d       = idx_q;
        cfg_err_d   = cfg_err_q;
        new_pulse_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rise_c) begin
                    t_lat_d   = T_IMPULSE;
                    num_lat_d = NUM_OF_IMP;
                    vob_lat_d = VOBULATION;
                    if (T_IMPULSE == '0) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        cfg_err_d   = 1'b0;
                        new_pulse_c = 1'b1;
                        state_d     = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (cnt_q == w_cyc_q - CNT_W'(1)) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == p_cyc_q - CNT_W'(1)) begin
                    if ((num_lat_q != '0) ? (idx_inc_c == num_lat_q) : !SIGN_START_GEN) begin
                        state_d = S_FINISH;
                    end else begin
                        new_pulse_c = 1'b1;
                        state_d     = S_PULSE;
                    end
                end
            end
            S_FINISH: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter restarts at every IMP_START so both limits are measured from it
        if (new_pulse_c) begin
            cnt_d     = '0;
            idx_d     = sel_idx_c;
            w_cyc_d   = CNT_W'(sel_t_c) * CNT_W'(CLK_PER_US);
            p_cyc_d   = CNT_W'(eff_p_c) * CNT_W'(CLK_PER_US);
            cfg_err_d = cfg_err_d | clamp_c;
        end

        gate_d      = (state_d == S_PULSE);
        busy_d      = (state_d == S_PULSE) || (state_d == S_GAP);
        done_d      = (state_d == S_FINISH);
        imp_start_d = new_pulse_c;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            t_lat_q     <= '0;
            num_lat_q   <= '0;
            vob_lat_q   <= 1'b0;
            cnt_q       <= '0;
            w_cyc_q     <= '0;
            p_cyc_q     <= '0;
            idx_q       <= '0;
            cfg_err_q   <= 1'b0;
            gate_q      <= 1'b0;
            imp_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= SIGN_START_GEN;
            t_lat_q     <= t_lat_d;
            num_lat_q   <= num_lat_d;
            vob_lat_q   <= vob_lat_d;
            cnt_q       <= cnt_d;
            w_cyc_q     <= w_cyc_d;
            p_cyc_q     <= p_cyc_d;
            idx_q       <= idx_d;
            cfg_err_q   <= cfg_err_d;
            gate_q      <= gate_d;
            imp_start_q <= imp_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Scoreboard bench for pulse_train_scheduler: a train-level model predicts every IMP_START/DONE
// event; a monitor pops and compares them as the DUT emits them.
module tb_pulse_train_scheduler;

    localparam int unsigned C   = 4;
    localparam int unsigned DEF = 360;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SIGN_START_GEN;
    logic [9:0]  T_IMPULSE;
    logic [5:0]  NUM_OF_IMP;
    logic        VOBULATION;
    logic        PERIOD_WR_EN;
    logic [4:0]  PERIOD_WR_ADDR;
    logic [12:0] PERIOD_WR_DATA;
    logic        GATE, IMP_START, BUSY, DONE, CFG_ERR;
    logic [5:0]  IMP_INDEX;

    pulse_train_scheduler #(.CLK_PER_US(C), .CNT_W(23), .DEFAULT_PERIOD(DEF)) dut (
        .CLK(CLK), .RESET(RESET), .SIGN_START_GEN(SIGN_START_GEN), .T_IMPULSE(T_IMPULSE),
        .NUM_OF_IMP(NUM_OF_IMP), .VOBULATION(VOBULATION), .PERIOD_WR_EN(PERIOD_WR_EN),
        .PERIOD_WR_ADDR(PERIOD_WR_ADDR), .PERIOD_WR_DATA(PERIOD_WR_DATA), .GATE(GATE),
        .IMP_START(IMP_START), .IMP_INDEX(IMP_INDEX), .BUSY(BUSY), .DONE(DONE), .CFG_ERR(CFG_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int cycle;
        int idx;
        bit err;
        int width;
    } ev_t;

    ev_t sb[$];
    int  tbl[32];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Train-level model: pulse k starts one full period after pulse k-1; the period is the
    // table entry (or entry 0) clamped up to width+1 us. Stops after max_p pulses (reset case).
    task automatic predict(input int s, input int t, input int n, input bit vob,
                           input int drop, input int max_p);
        int tt  = s + 1;
        bit err = 0;
        ev_t e;
        if (t == 0) begin
            e = '{1'b1, s + 1, 0, 1'b1, 0};
            sb.push_back(e);
            return;
        end
        for (int k = 0; k < 1000; k++) begin
            int ent = tbl[vob ? (k % 32) : 0];
            int p   = (ent < t + 1) ? t + 1 : ent;
            if (ent < t + 1) err = 1;
            if (k == max_p) return;
            e = '{1'b0, tt, k % 64, err, t * C};
            sb.push_back(e);
            tt += p * C;
            if ((n != 0) ? (k + 1 == n) : (drop < tt)) begin
                e = '{1'b1, tt, 0, err, 0};
                sb.push_back(e);
                return;
            end
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge
    int run = 0;
    int exp_w = 0;
    int cur_idx = 0;
    always begin
        ev_t e;
        @(posedge CLK);
        #1;
        if (IMP_START || DONE) begin
            chk("event_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("event_kind", int'(DONE), int'(e.is_done));
                chk("event_cycle", cyc, e.cycle);
                chk("cfg_err", int'(CFG_ERR), int'(e.err));
                if (e.is_done) begin
                    chk("busy_at_done", int'(BUSY), 0);
                    chk("gate_at_done", int'(GATE), 0);
                end else begin
                    chk("imp_index", int'(IMP_INDEX), e.idx);
                    chk("busy_at_start", int'(BUSY), 1);
                    exp_w   = e.width;
                    cur_idx = e.idx;
                end
            end
        end
        if (GATE) begin
            if (run == 0) chk("gate_rise_with_imp_start", int'(IMP_START), 1);
            run++;
        end else if (run != 0) begin
            chk("gate_width", run, exp_w);
            chk("imp_index_held", int'(IMP_INDEX), cur_idx);
            run = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input int a, input int d);
        PERIOD_WR_EN   = 1'b1;
        PERIOD_WR_ADDR = 5'(a);
        PERIOD_WR_DATA = 13'(d);
        tbl[a]         = d;
        tick();
        PERIOD_WR_EN   = 1'b0;
    endtask

    // Raises the start level (after one low cycle); returns the cycle the rise is set up in
    task automatic start(input int t, input int n, input bit vob, input int drop_rel,
                         input int max_p, output int s);
        SIGN_START_GEN = 1'b0;
        tick();
        T_IMPULSE      = 10'(t);
        NUM_OF_IMP     = 6'(n);
        VOBULATION     = vob;
        SIGN_START_GEN = 1'b1;
        s              = cyc;
        predict(s, t, n, vob, s + drop_rel, max_p);
        tick();
        T_IMPULSE  = 10'($urandom_range(0, 1023));
        NUM_OF_IMP = 6'($urandom_range(0, 63));
        VOBULATION = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !BUSY && !DONE) break;
            tick();
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
        SIGN_START_GEN = 1'b0;
        tick(2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gate"}, int'(GATE), 0);
        chk({tag, "_imp_start"}, int'(IMP_START), 0);
        chk({tag, "_imp_index"}, int'(IMP_INDEX), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_done"}, int'(DONE), 0);
        chk({tag, "_cfg_err"}, int'(CFG_ERR), 0);
    endtask

    initial begin
        int s;
        RESET = 1'b1; SIGN_START_GEN = 1'b0; T_IMPULSE = '0; NUM_OF_IMP = '0; VOBULATION = 1'b0;
        PERIOD_WR_EN = 1'b0; PERIOD_WR_ADDR = '0; PERIOD_WR_DATA = '0;
        for (int i = 0; i < 32; i++) tbl[i] = DEF;
        tick(3);
        chk_zero("in_reset");
        RESET = 1'b0;
        tick(2);
        chk_zero("after_reset");

        // Basic vobulated train, with a re-rise while busy that must be ignored
        wr(0, 2); wr(1, 3); wr(2, 4);
        start(1, 3, 1'b1, 0, 1000, s);
        until_cyc(s + 5);  SIGN_START_GEN = 1'b0;
        until_cyc(s + 6);  SIGN_START_GEN = 1'b1;
        until_cyc(s + 10); SIGN_START_GEN = 1'b0;
        wait_done(200);
        chk("cfg_err_idle_basic", int'(CFG_ERR), 0);
        chk("imp_index_idle", int'(IMP_INDEX), 0);

        // Vobulation off
        start(1, 3, 1'b0, 0, 1000, s);
        wait_done(200);

        // Clamp: sticky error survives into idle, cleared by the next accepted start
        wr(0, 1);
        start(2, 2, 1'b0, 0, 1000, s);
        wait_done(200);
        chk("cfg_err_sticky_idle", int'(CFG_ERR), 1);
        wr(0, 2);
        start(1, 1, 1'b0, 0, 1000, s);
        wait_done(200);

        // Zero width
        start(0, 3, 1'b0, 0, 1000, s);
        wait_done(50);
        chk("cfg_err_zero_width", int'(CFG_ERR), 1);

        // Continuous mode: brief dip inside pulse 0 is a rise while busy; final drop in pulse 3
        start(1, 0, 1'b0, 26, 1000, s);
        until_cyc(s + 3);  SIGN_START_GEN = 1'b0;
        until_cyc(s + 4);  SIGN_START_GEN = 1'b1;
        until_cyc(s + 26); SIGN_START_GEN = 1'b0;
        wait_done(200);

        // Live write to entry 1 during pulse 0 is used by pulse 1
        wr(1, 3);
        SIGN_START_GEN = 1'b0;
        tick();
        T_IMPULSE = 10'd1; NUM_OF_IMP = 6'd2; VOBULATION = 1'b1; SIGN_START_GEN = 1'b1;
        s = cyc;
        tbl[1] = 5;
        predict(s, 1, 2, 1'b1, 0, 1000);
        tick(2);
        PERIOD_WR_EN = 1'b1; PERIOD_WR_ADDR = 5'd1; PERIOD_WR_DATA = 13'd5;
        tick();
        PERIOD_WR_EN = 1'b0;
        wait_done(200);

        // Randomized trains
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 8; a++) wr(a, $urandom_range(1, 6));
            start($urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                  0, 1000, s);
            wait_done(1000);
        end

        // Reset in the gap of pulse 1: outputs clear, no DONE, table back to default
        wr(0, 2); wr(1, 3);
        start(1, 3, 1'b1, 0, 2, s);
        SIGN_START_GEN = 1'b0;
        until_cyc(s + 14);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_zero("mid_train_reset");
        chk("reset_events_consumed", sb.size(), 0);
        for (int i = 0; i < 32; i++) tbl[i] = DEF;
        tick(40);

        // Train after reset uses the default period
        start(1, 1, 1'b0, 0, 1000, s);
        wait_done(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
